// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-input, WIDTH-bit stream multiplexer with a one-entry registered
// output and valid/ready handshakes on every port.
//
// A fixed-select mode (mode=0, channel chosen by sel) and a round-robin mode
// (mode=1, search starts at ptr) share the same grant/ready path.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   mode       0 = fixed select via sel, 1 = round-robin among valid inputs
//   sel        channel index used in fixed mode (indices >= N grant nothing)
//   in_data    N packed channels, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit set)
//   out_data   registered data word
//   out_ch     channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word when out_valid & out_ready

// Per-channel slice: ready gating and data masking for one input.
module mux_nx1_rr_lane #(
   parameter int WIDTH = 8
) (
   input  logic             grant,
   input  logic             load_en,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   output logic             ready,
   output logic [WIDTH-1:0] data_sel
);
   // Ready is forced low while reset is held, independent of the clock.
   assign ready    = grant & load_en & ~rst;
   assign data_sel = grant ? data : '0;
endmodule

module mux_nx1_rr #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_ch,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [SELW-1:0]           ptr;
   logic [N-1:0]              grant;
   logic [N-1:0][WIDTH-1:0]   lane_data;
   logic [WIDTH-1:0]          mux_data;
   logic [SELW-1:0]           grant_ch;
   logic                      load_en;
   logic                      xfer;
   logic                      found;
   int                        idx;

   // Register can refill in the same cycle its word leaves.
   assign load_en = ~out_valid | out_ready;

   // Grant: one-hot or zero.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      if (!mode) begin
         // An out-of-range sel never matches any index, so nothing is granted.
         for (int i = 0; i < N; i++)
            if (sel == SELW'(i)) grant[i] = in_valid[i];
      end else begin
         // Search ptr, ptr+1, ... wrapping modulo N; first valid wins.
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && in_valid[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      mux_nx1_rr_lane #(.WIDTH(WIDTH)) u_lane (
         .grant    (grant[i]),
         .load_en  (load_en),
         .rst      (rst),
         .data     (in_data[i*WIDTH +: WIDTH]),
         .ready    (in_ready[i]),
         .data_sel (lane_data[i])
      );
   end

   // Grant is one-hot, so OR-reducing the masked lanes selects the winner.
   always_comb begin
      mux_data = '0;
      grant_ch = '0;
      for (int i = 0; i < N; i++) begin
         mux_data = mux_data | lane_data[i];
         if (grant[i]) grant_ch = SELW'(i);
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_ch    <= grant_ch;
            // Pointer only advances on a round-robin transfer.
            if (mode) begin
               if (int'(grant_ch) == N - 1) ptr <= '0;
               else                         ptr <= grant_ch + 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr: a 4-channel instance for the main scenarios
// and a 3-channel instance for the out-of-range select case.
module tb_mux_nx1_rr;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        mode = 1'b0;
   logic [1:0]  sel = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready = 1'b0;

   logic        mode3 = 1'b0;
   logic [1:0]  sel3 = '0;
   logic [23:0] in_data3 = '0;
   logic [2:0]  in_valid3 = '0;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic [1:0]  out_ch3;
   logic        out_valid3;
   logic        out_ready3 = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux_nx1_rr #(.N(4), .WIDTH(8)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_nx1_rr #(.N(3), .WIDTH(8)) dut3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
      .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
      .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Short asynchronous reset pulse, issued away from clock edges.
   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 4'b1111;
      mode     = 1'b1;
      #2;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", out_data); end
      n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
      rst = 1'b0;
      in_valid = '0;
      tick();
   endtask

   task automatic test_fixed();
      pulse_reset();
      mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready[%0d] got=%b exp=0100", k, in_ready); end
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL fixed_out[%0d] got=v%b d%h c%0d exp=v1 d33 c2", k, out_valid, out_data, out_ch); end
      end
      in_valid = '0;
   endtask

   task automatic test_sel_oob();
      pulse_reset();
      mode3 = 1'b0; sel3 = 2'd1; out_ready3 = 1'b1;
      in_data3 = {8'hC3, 8'hB2, 8'hA1}; in_valid3 = 3'b111;
      tick();
      n_cmp++; if (out_valid3 !== 1'b1 || out_data3 !== 8'hB2 || out_ch3 !== 2'd1) begin
         n_err++; $display("FAIL oob_first got=v%b d%h c%0d exp=v1 dB2 c1", out_valid3, out_data3, out_ch3); end
      sel3 = 2'd3;
      #1;
      n_cmp++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL oob_ready got=%b exp=000", in_ready3); end
      tick();
      n_cmp++; if (out_valid3 !== 1'b0 || out_data3 !== 8'hB2 || out_ch3 !== 2'd1) begin
         n_err++; $display("FAIL oob_drain got=v%b d%h c%0d exp=v0 dB2 c1", out_valid3, out_data3, out_ch3); end
      n_cmp++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL oob_ready2 got=%b exp=000", in_ready3); end
      in_valid3 = '0;
   endtask

   task automatic test_rr_fair();
      logic [7:0] exp_d;
      logic [3:0] exp_r;
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp_r = 4'b0001 << (k % 4);
         exp_d = 8'(8'h11 * ((k % 4) + 1));
         #1;
         n_cmp++; if (in_ready !== exp_r) begin n_err++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, in_ready, exp_r); end
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== exp_d) begin
            n_err++; $display("FAIL rr_out[%0d] got=v%b c%0d d%h exp=v1 c%0d d%h", k, out_valid, out_ch, out_data, k % 4, exp_d); end
      end
      in_valid = '0;
   endtask

   task automatic test_sparse();
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid = 4'b0001;               // ch0 transfer moves ptr to 1
      tick();
      in_valid = 4'b1001;
      #1;
      n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL sparse_r0 got=%b exp=1000", in_ready); end
      tick();
      n_cmp++; if (out_ch !== 2'd3 || out_data !== 8'h44) begin n_err++; $display("FAIL sparse_o0 got=c%0d d%h exp=c3 d44", out_ch, out_data); end
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL sparse_r1 got=%b exp=0001", in_ready); end
      tick();
      n_cmp++; if (out_ch !== 2'd0 || out_data !== 8'h11) begin n_err++; $display("FAIL sparse_o1 got=c%0d d%h exp=c0 d11", out_ch, out_data); end
      #1;
      n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL sparse_r2 got=%b exp=1000", in_ready); end
      tick();
      n_cmp++; if (out_ch !== 2'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL sparse_o2 got=c%0d v%b exp=c3 v1", out_ch, out_valid); end
      in_valid = '0;
   endtask

   task automatic test_backpressure();
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'hA5, 8'h11};
      in_valid = 4'b0001; tick();       // ptr -> 1
      in_valid = 4'b0010; tick();       // hold A5 from ch1, ptr -> 2
      out_ready = 1'b0; in_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, in_ready); end
         tick();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd1) begin
            n_err++; $display("FAIL bp_hold[%0d] got=v%b d%h c%0d exp=v1 dA5 c1", k, out_valid, out_data, out_ch); end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h33) begin
         n_err++; $display("FAIL bp_next got=v%b c%0d d%h exp=v1 c2 d33", out_valid, out_ch, out_data); end
      in_valid = '0;
   endtask

   task automatic test_mode_switch();
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid = 4'b0001; tick();       // ptr -> 1
      in_valid = 4'b0010; tick();       // hold 22 from ch1, ptr -> 2
      out_ready = 1'b0; in_valid = 4'b1111;
      tick();
      mode = 1'b0; sel = 2'd0;
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL ms_stall_ready got=%b exp=0000", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd1) begin
         n_err++; $display("FAIL ms_hold got=v%b d%h c%0d exp=v1 d22 c1", out_valid, out_data, out_ch); end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL ms_ready got=%b exp=0001", in_ready); end
      tick();
      n_cmp++; if (out_ch !== 2'd0 || out_data !== 8'h11) begin n_err++; $display("FAIL ms_next got=c%0d d%h exp=c0 d11", out_ch, out_data); end
      in_valid = '0;
   endtask

   task automatic test_reset_midstream();
      pulse_reset();
      mode = 1'b1; out_ready = 1'b1;
      in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_valid = 4'b1111;
      tick(); tick();                    // ptr now 2, holding ch1
      out_ready = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got=%b exp=1", out_valid); end
      #3;
      rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
         n_err++; $display("FAIL rstmid_out got=v%b d%h c%0d exp=v0 d00 c0", out_valid, out_data, out_ch); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready got=%b exp=0000", in_ready); end
      #1;
      rst = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_first_ready got=%b exp=0001", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
         n_err++; $display("FAIL rstmid_first got=v%b c%0d d%h exp=v1 c0 d11", out_valid, out_ch, out_data); end
      in_valid = '0;
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_sel_oob();
      test_rr_fair();
      test_sparse();
      test_backpressure();
      test_mode_switch();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
